// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS instruction-fetch stage: PC register, next-PC select, IF/ID register
//
// Optional feature macro: FETCH_PERF_EN (stall/flush performance counters).
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   pc_load               1 = PC may advance, 0 = hold PC (load-use stall)
//   ifid_ld               1 = IF/ID may load, 0 = hold IF/ID
//   branch_taken/_target  taken branch resolved in ID, destination address
//   jump/jump_target      j/jal/jr resolved in ID, destination address
//   imem_addr             fetch address (current PC, word aligned)
//   imem_rdata/imem_ready instruction word and its valid flag
//   fetch_pc              current PC register value
//   ifid_instr/_pc4/_valid IF/ID pipeline register contents
//   perf_stall_cnt        saturating stall-cycle counter (0 when FETCH_PERF_EN undefined)
//   perf_flush_cnt        saturating flush counter (0 when FETCH_PERF_EN undefined)
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_load,
  input  logic        ifid_ld,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] fetch_pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  // PC is kept word aligned, so even a misaligned RESET_PC is forced onto a word.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        redirect;
  logic [31:0] pc_plus4;

  // Target low bits are ignored: fetches are always word aligned.
  logic unused_target_bits;
  assign unused_target_bits = ^{branch_target[1:0], jump_target[1:0]};

  assign redirect = branch_taken | jump;
  assign pc_plus4 = pc_q + 32'd4;  // wraps modulo 2^32

  always_comb begin
    pc_d = pc_q;
    if (branch_taken) begin
      pc_d = {branch_target[31:2], 2'b00};
    end else if (jump) begin
      pc_d = {jump_target[31:2], 2'b00};
    end else if (pc_load && imem_ready) begin
      pc_d = pc_plus4;
    end
  end

  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (redirect) begin
      // Wrong-path instruction fetched this cycle is squashed; pc4 is left alone.
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (!ifid_ld) begin
      // hold all of IF/ID
    end else if (!imem_ready) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else begin
      // With pc_load=0 this deliberately re-captures the same PC (duplicate fetch).
      ifid_instr_d = imem_rdata;
      ifid_pc4_d   = pc_plus4;
      ifid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC_ALIGNED;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_addr  = pc_q;
  assign fetch_pc   = pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_valid = ifid_valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_load && !redirect && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (redirect && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed table-driven bench for if_fetch_stage
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        pc_load;
  logic        ifid_ld;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] fetch_pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  int checks;
  int failures;

  if_fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_load        (pc_load),
    .ifid_ld        (ifid_ld),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .fetch_pc       (fetch_pc),
    .ifid_instr     (ifid_instr),
    .ifid_pc4       (ifid_pc4),
    .ifid_valid     (ifid_valid),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a recognisable word derived from the address.
  function automatic logic [31:0] ins(input logic [31:0] a);
    return {16'hDEAD, a[15:0]};
  endfunction

  assign imem_rdata = ins(imem_addr);

  typedef struct {
    logic        pl;
    logic        ld;
    logic        br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic        rdy;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t row(input logic pl, input logic ld, input logic br, input logic [31:0] bt,
                               input logic jp, input logic [31:0] jt, input logic rdy,
                               input logic [31:0] e_pc, input logic [31:0] e_instr,
                               input logic [31:0] e_pc4, input logic e_valid);
    vec_t v;
    v.pl = pl; v.ld = ld; v.br = br; v.bt = bt; v.jp = jp; v.jt = jt; v.rdy = rdy;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pl, input logic ld, input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt, input logic rdy);
    pc_load = pl; ifid_ld = ld; branch_taken = br; branch_target = bt;
    jump = jp; jump_target = jt; imem_ready = rdy;
  endtask

  // Apply inputs, take one rising edge, sample 1 ns later.
  task automatic step(input logic pl, input logic ld, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt, input logic rdy);
    drive(pl, ld, br, bt, jp, jt, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"},    fetch_pc,   32'h0);
    chk({tag, "_addr"},  imem_addr,  32'h0);
    chk({tag, "_instr"}, ifid_instr, 32'h0);
    chk({tag, "_pc4"},   ifid_pc4,   32'h0);
    chk({tag, "_valid"}, {31'd0, ifid_valid}, 32'h0);
    chk({tag, "_stall"}, perf_stall_cnt, 32'h0);
    chk({tag, "_flush"}, perf_flush_cnt, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;
    checks   = 0;
    failures = 0;

    //            pl ld br bt            jp jt            rdy  pc            instr              pc4           v
    vecs.push_back(row(1, 1, 0, 32'h0,   0, 32'h0,        1, 32'h4,        ins(32'h0),        32'h4,        1));
    vecs.push_back(row(1, 1, 0, 32'h0,   0, 32'h0,        1, 32'h8,        ins(32'h4),        32'h8,        1));
    vecs.push_back(row(1, 1, 0, 32'h0,   0, 32'h0,        1, 32'hC,        ins(32'h8),        32'hC,        1));
    vecs.push_back(row(1, 1, 0, 32'h0,   0, 32'h0,        1, 32'h10,       ins(32'hC),        32'h10,       1));
    // load-use stall for two cycles at PC=0x10
    vecs.push_back(row(0, 0, 0, 32'h0,   0, 32'h0,        1, 32'h10,       ins(32'hC),        32'h10,       1));
    vecs.push_back(row(0, 0, 0, 32'h0,   0, 32'h0,        1, 32'h10,       ins(32'hC),        32'h10,       1));
    vecs.push_back(row(1, 1, 0, 32'h0,   0, 32'h0,        1, 32'h14,       ins(32'h10),       32'h14,       1));
    // branch to misaligned 0x103 during a stall: redirect wins, flush
    vecs.push_back(row(0, 1, 1, 32'h103, 0, 32'h0,        1, 32'h100,      32'h0,             32'h14,       0));
    vecs.push_back(row(1, 1, 0, 32'h0,   0, 32'h0,        1, 32'h104,      ins(32'h100),      32'h104,      1));
    // branch and jump together: branch wins
    vecs.push_back(row(1, 1, 1, 32'h200, 1, 32'h300,      1, 32'h200,      32'h0,             32'h104,      0));
    vecs.push_back(row(1, 1, 0, 32'h0,   1, 32'h40,       1, 32'h40,       32'h0,             32'h104,      0));
    // memory wait three cycles at 0x40
    vecs.push_back(row(1, 1, 0, 32'h0,   0, 32'h0,        0, 32'h40,       32'h0,             32'h104,      0));
    vecs.push_back(row(1, 1, 0, 32'h0,   0, 32'h0,        0, 32'h40,       32'h0,             32'h104,      0));
    vecs.push_back(row(1, 1, 0, 32'h0,   0, 32'h0,        0, 32'h40,       32'h0,             32'h104,      0));
    vecs.push_back(row(1, 1, 0, 32'h0,   0, 32'h0,        1, 32'h44,       ins(32'h40),       32'h44,       1));
    // PC held but IF/ID loads: duplicate fetch of 0x44
    vecs.push_back(row(0, 1, 0, 32'h0,   0, 32'h0,        1, 32'h44,       ins(32'h44),       32'h48,       1));
    // PC advances but IF/ID held
    vecs.push_back(row(1, 0, 0, 32'h0,   0, 32'h0,        1, 32'h48,       ins(32'h44),       32'h48,       1));
    // jump overrides stall and memory wait; target aligned down
    vecs.push_back(row(0, 0, 0, 32'h0,   1, 32'hFFFFFFFE, 0, 32'hFFFFFFFC, 32'h0,             32'h48,       0));
    // wrap from 0xFFFFFFFC to 0
    vecs.push_back(row(1, 1, 0, 32'h0,   0, 32'h0,        1, 32'h0,        ins(32'hFFFFFFFC), 32'h0,        1));
    // ifid_ld=0 has priority over a memory-wait bubble
    vecs.push_back(row(1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        ins(32'hFFFFFFFC), 32'h0,        1));

    drive(1, 1, 0, 32'h0, 0, 32'h0, 1);
    rst_n = 1'b0;
    #2;
    chk_reset_state("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // run a few cycles, then assert reset mid-cycle and check it takes effect before any edge
    step(1, 1, 0, 32'h0, 0, 32'h0, 1);
    step(1, 1, 0, 32'h0, 0, 32'h0, 1);
    step(0, 1, 0, 32'h0, 0, 32'h0, 1);
    step(1, 1, 1, 32'h80, 0, 32'h0, 1);
    chk("pre_reset_pc", fetch_pc, 32'h80);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].pl, vecs[i].ld, vecs[i].br, vecs[i].bt, vecs[i].jp, vecs[i].jt, vecs[i].rdy);
      chk($sformatf("v%0d_pc", i),    fetch_pc,   vecs[i].e_pc);
      chk($sformatf("v%0d_addr", i),  imem_addr,  vecs[i].e_pc);
      chk($sformatf("v%0d_instr", i), ifid_instr, vecs[i].e_instr);
      chk($sformatf("v%0d_pc4", i),   ifid_pc4,   vecs[i].e_pc4);
      chk($sformatf("v%0d_valid", i), {31'd0, ifid_valid}, {31'd0, vecs[i].e_valid});
    end

    // Performance counter sequence from a fresh reset.
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("perf_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 32'h0, 0, 32'h0, 1);
    step(1, 1, 0, 32'h0, 0, 32'h0, 0);            // memory wait alone is not a stall
    step(0, 1, 1, 32'h60, 0, 32'h0, 1);           // stalled redirect counts only as a flush
    step(1, 1, 0, 32'h0, 1, 32'h70, 1);
    step(1, 1, 0, 32'h0, 0, 32'h0, 1);
`ifdef FETCH_PERF_EN
    exp_stall = 32'd5;
    exp_flush = 32'd2;
`else
    exp_stall = 32'd0;
    exp_flush = 32'd0;
`endif
    chk("perf_stall", perf_stall_cnt, exp_stall);
    chk("perf_flush", perf_flush_cnt, exp_flush);
    chk("perf_pc", fetch_pc, 32'h74);
    chk("perf_instr", ifid_instr, ins(32'h70));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, next-PC selection and the IF/ID pipeline register.
- Directly upstream of the ID stage and the load-use hazard detection unit. Consumes that unit's pc_load / IFID_Ld stall controls, and the branch/jump redirect resolved in ID.
- Drives a word-addressed instruction memory with a ready handshake; inserts bubbles on memory wait and flushes on redirect.

Parameters:
RESET_PC  32'h00000000  PC value loaded on reset
NOP_INSTR  32'h00000000  encoding written into IF/ID on bubble/flush (sll $0,$0,0)

Ports:
clk  input  1  pipeline clock, rising-edge
rst_n  input  1  asynchronous active-low reset
pc_load  input  1  1 = PC may advance; 0 = hold PC (load-use stall)
ifid_ld  input  1  1 = IF/ID may load; 0 = hold IF/ID contents
branch_taken  input  1  taken branch resolved in ID this cycle
branch_target  input  32  branch destination address
jump  input  1  j/jal/jr resolved in ID this cycle
jump_target  input  32  jump destination address
imem_addr  output  32  fetch address (equals current PC, combinational)
imem_rdata  input  32  instruction word at imem_addr
imem_ready  input  1  imem_rdata valid this cycle
fetch_pc  output  32  current PC register value
ifid_instr  output  32  registered instruction for ID
ifid_pc4  output  32  registered PC+4 of that instruction
ifid_valid  output  1  1 = IF/ID holds a real instruction
perf_stall_cnt  output  32  stall-cycle counter (see Optional Feature)
perf_flush_cnt  output  32  flush counter (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): PC=RESET_PC; ifid_instr=NOP_INSTR; ifid_pc4=0; ifid_valid=0; both perf counters=0. Outputs reach these values immediately on reset assertion, without waiting for a clock edge.
- Reset mid-operation discards any in-flight fetch. First fetch after rst_n rises is at RESET_PC on the next edge.
- imem_addr = PC; bits [1:0] always 0.
- redirect = branch_taken | jump. If both are high, branch_taken wins.
- Next PC, priority high to low:
  1. branch_taken -> {branch_target[31:2],2'b00}
  2. jump -> {jump_target[31:2],2'b00}
  3. pc_load=0 -> hold
  4. imem_ready=0 -> hold
  5. else PC+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000)
- Redirect overrides a simultaneous stall (pc_load=0) and a simultaneous imem_ready=0.
- IF/ID update each edge, priority high to low:
  1. redirect -> flush: instr=NOP_INSTR, valid=0, pc4 unchanged
  2. ifid_ld=0 -> hold all three
  3. imem_ready=0 -> bubble: instr=NOP_INSTR, valid=0
  4. else instr=imem_rdata, pc4=PC+4, valid=1
- Latency: instruction at PC appears in IF/ID one edge after imem_ready=1 with no stall and no redirect.
- Redirect costs exactly one bubble. The target instruction reaches IF/ID on the second edge after redirect if the memory is ready.
- pc_load and ifid_ld are independent inputs. Any combination is legal and follows the rules above; hazard unit normally drives both low together.
- ifid_ld=1 with pc_load=0 re-fetches the same PC into IF/ID (duplicate); this is defined behaviour.
- No combinational path from any input to any output except imem_rdata-independent imem_addr (from PC register).

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - perf_stall_cnt increments on every edge where pc_load=0 and redirect=0.
  - perf_flush_cnt increments on every edge where redirect=1.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: both ports tied to constant 0, no counter flops.
- Port list is identical either way.

Test Plan:
- Reset with rst_n=0 mid-cycle -> fetch_pc=0, ifid_valid=0, ifid_instr=0 before next edge. Release; imem_ready=1 -> fetch_pc 0,4,8; ifid_pc4 4,8,12 one edge later.
- At PC=0x10, pc_load=0 and ifid_ld=0 for 2 cycles -> fetch_pc stays 0x10; IF/ID holds instr from 0x0C. Release -> PC=0x14.
- branch_taken=1, branch_target=0x103 while pc_load=0 -> next PC=0x100; ifid_valid=0, ifid_instr=0; next edge IF/ID holds instr@0x100 with pc4=0x104.
- branch_taken=1 and jump=1 together (targets 0x200 / 0x300) -> PC=0x200.
- imem_ready=0 for 3 cycles at PC=0x40 -> PC holds 0x40; 3 bubbles (valid=0); then instr@0x40 loads with pc4=0x44. Separately, PC=0xFFFFFFFC advance -> PC=0x00000000, pc4=0x00000000.
- FETCH_PERF_EN defined: 5 stall cycles + 2 redirects -> perf_stall_cnt=5, perf_flush_cnt=2. Undefined: both read 0.
